// File: rtl/dac_i2s_tdm.sv
// dac_i2s_tdm: multi-channel I2S / left- / right-justified DAC serialiser with frame FIFO.
// BCLK is external and asynchronous; it is synchronised into CLK and its falling edges
// ("ticks") step the frame position. Outputs update on the CLK cycle after each tick.
// Optional build macro DAC_I2S_TDM_HOLD_LAST_EN: on underrun repeat the last frame
// instead of emitting silence.
`timescale 1ns / 1ps

module dac_i2s_tdm #(
    parameter int unsigned SAMPLE_WIDTH = 16,
    parameter int unsigned SLOT_WIDTH   = 32,
    parameter int unsigned CHANNELS     = 2,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                               CLK,
    input  logic                               RESET_n,
    input  logic                               ENABLE,
    input  logic [1:0]                         MODE,
    input  logic                               IN_VALID,
    output logic                               IN_READY,
    input  logic [CHANNELS*SAMPLE_WIDTH-1:0]   IN_DATA,
    output logic [$clog2(FIFO_DEPTH):0]        FIFO_LEVEL,
    output logic                               UNDERRUN,
    input  logic                               BCLK,
    output logic                               LRCLK,
    output logic                               DIN
);

    localparam int unsigned FW  = CHANNELS * SAMPLE_WIDTH;
    localparam int unsigned AW  = $clog2(FIFO_DEPTH);
    localparam int unsigned SW  = $clog2(CHANNELS);
    localparam int unsigned BW  = $clog2(SLOT_WIDTH);
    localparam int unsigned PAD = SLOT_WIDTH - SAMPLE_WIDTH;

    localparam logic [1:0] MODE_LJ = 2'd1;
    localparam logic [1:0] MODE_RJ = 2'd2;

    localparam logic [AW:0]   DEPTH_L   = (AW + 1)'(FIFO_DEPTH);
    localparam logic [BW-1:0] SLOT_LAST = BW'(SLOT_WIDTH - 1);
    localparam logic [SW-1:0] CH_LAST   = SW'(CHANNELS - 1);
    localparam logic [SW-1:0] CH_HALF   = SW'(CHANNELS / 2);

    if (SAMPLE_WIDTH > SLOT_WIDTH) begin : g_bad_sample
        $error("SAMPLE_WIDTH must not exceed SLOT_WIDTH");
    end
    if (SLOT_WIDTH < 16) begin : g_bad_slot
        $error("SLOT_WIDTH must be at least 16");
    end
    if ((CHANNELS < 2) || (CHANNELS % 2 != 0)) begin : g_bad_ch
        $error("CHANNELS must be even and at least 2");
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of 2 and at least 2");
    end

    // ---------------------------------------------------------------- BCLK sync
    logic bclk_s1_q, bclk_s2_q, bclk_s3_q;
    logic tick;

    // Two-FF synchroniser plus one delay stage for falling-edge detection.
    always_ff @(posedge CLK) begin
        if (!RESET_n) begin
            bclk_s1_q <= 1'b0;
            bclk_s2_q <= 1'b0;
            bclk_s3_q <= 1'b0;
        end else begin
            bclk_s1_q <= BCLK;
            bclk_s2_q <= bclk_s1_q;
            bclk_s3_q <= bclk_s2_q;
        end
    end

    assign tick = bclk_s3_q & ~bclk_s2_q;

    // ---------------------------------------------------------------- FIFO
    logic [FW-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   level_q, level_d;
    logic          in_ready_q;
    logic          wr_en, rd_en, fifo_empty, fetch;

    assign wr_en      = IN_VALID & in_ready_q;
    assign fifo_empty = (level_q == '0);
    assign rd_en      = fetch & ~fifo_empty;

    // Level tracks writes and fetches; a simultaneous write and read leaves it unchanged.
    always_comb begin
        level_d = level_q;
        if (wr_en && !rd_en) begin
            level_d = level_q + 1'b1;
        end else if (!wr_en && rd_en) begin
            level_d = level_q - 1'b1;
        end
    end

    // Storage array; no reset needed since the pointers define what is valid.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= IN_DATA;
        end
    end

    // Pointers, level and a registered ready that is held low during reset.
    always_ff @(posedge CLK) begin
        if (!RESET_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            in_ready_q <= 1'b0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q    <= level_d;
            in_ready_q <= (level_d != DEPTH_L);
        end
    end

    // ---------------------------------------------------------------- serialiser
    logic [SW-1:0]           slot_q, s;
    logic [BW-1:0]           bit_q, b;
    logic [1:0]              mode_q, mode_cur;
    logic                    first_q;
    logic [FW-1:0]           frame_q, frame_d, frame_sh;
    logic [SAMPLE_WIDTH-1:0] sample, sample_sh;
    logic [31:0]             b_int;
    logic                    lrclk_q, din_q, underrun_q;
    logic                    step, p_zero, p_one, is_i2s, is_rj, data_bit, lrclk_d;

    assign step     = tick & ENABLE;
    assign p_zero   = (slot_q == '0) && (bit_q == '0);
    assign p_one    = (slot_q == '0) && (bit_q == BW'(1));
    // MODE is only sampled at p = 0; elsewhere the latched copy applies.
    assign mode_cur = p_zero ? MODE : mode_q;
    assign is_rj    = (mode_cur == MODE_RJ);
    assign is_i2s   = (mode_cur != MODE_LJ) && !is_rj;
    assign fetch    = step & (is_i2s ? p_one : p_zero);
    assign lrclk_d  = (slot_q >= CH_HALF);

    // Slot/bit of the data being sent: I2S lags the position by one BCLK.
    always_comb begin
        s = slot_q;
        b = bit_q;
        if (is_i2s) begin
            if (bit_q == '0) begin
                b = SLOT_LAST;
                s = (slot_q == '0) ? CH_LAST : slot_q - 1'b1;
            end else begin
                b = bit_q - 1'b1;
            end
        end
    end

    // Frame register next state: load the FIFO head at the fetch point, else handle underrun.
    always_comb begin
        frame_d = frame_q;
        if (fetch) begin
            if (!fifo_empty) begin
                frame_d = mem_q[rd_ptr_q];
            end else begin
`ifdef DAC_I2S_TDM_HOLD_LAST_EN
                frame_d = frame_q;
`else
                frame_d = '0;
`endif
            end
        end
    end

    // Bit selection from the (possibly just-fetched) frame.
    always_comb begin
        frame_sh  = frame_d >> (32'(s) * SAMPLE_WIDTH);
        sample    = frame_sh[SAMPLE_WIDTH-1:0];
        b_int     = 32'(b);
        sample_sh = '0;
        data_bit  = 1'b0;
        if (is_rj) begin
            if (b_int >= PAD) begin
                sample_sh = sample >> (SAMPLE_WIDTH - 1 - (b_int - PAD));
                data_bit  = sample_sh[0];
            end else begin
                data_bit = sample[SAMPLE_WIDTH-1];
            end
        end else if (b_int < SAMPLE_WIDTH) begin
            sample_sh = sample >> (SAMPLE_WIDTH - 1 - b_int);
            data_bit  = sample_sh[0];
        end
        // No previous frame exists for the I2S boundary bit right after enabling.
        if (is_i2s && p_zero && first_q) begin
            data_bit = 1'b0;
        end
    end

    // Position counters, latched mode, frame register and output pins.
    always_ff @(posedge CLK) begin
        if (!RESET_n) begin
            slot_q     <= '0;
            bit_q      <= '0;
            mode_q     <= '0;
            first_q    <= 1'b1;
            frame_q    <= '0;
            lrclk_q    <= 1'b0;
            din_q      <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            underrun_q <= fetch & fifo_empty;
            frame_q    <= frame_d;
            if (!ENABLE) begin
                slot_q  <= '0;
                bit_q   <= '0;
                lrclk_q <= 1'b0;
                din_q   <= 1'b0;
                first_q <= 1'b1;
            end else if (tick) begin
                lrclk_q <= lrclk_d;
                din_q   <= data_bit;
                first_q <= 1'b0;
                if (p_zero) mode_q <= MODE;
                if (bit_q == SLOT_LAST) begin
                    bit_q  <= '0;
                    slot_q <= (slot_q == CH_LAST) ? '0 : slot_q + 1'b1;
                end else begin
                    bit_q <= bit_q + 1'b1;
                end
            end
        end
    end

    assign IN_READY   = in_ready_q;
    assign FIFO_LEVEL = level_q;
    assign UNDERRUN   = underrun_q;
    assign LRCLK      = lrclk_q;
    assign DIN        = din_q;

endmodule

// File: tb/tb_dac_i2s_tdm.sv
// Testbench for dac_i2s_tdm: default 2x16/32 instance plus a 4-channel 24-bit instance.
`timescale 1ns / 1ps

module tb_dac_i2s_tdm;

    logic        CLK = 1'b0;
    logic        BCLK = 1'b1;
    logic        RESET_n = 1'b0;
    logic        run = 1'b0;
    logic        sel = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic        in_valid = 1'b0;
    logic [95:0] in_data = '0;

    logic       en0, en1, vld0, vld1;
    logic       rdy0, rdy1, ur0, ur1, lr0, lr1, din0, din1;
    logic [2:0] lvl0, lvl1;
    logic       obs_ready, obs_din, obs_lr;
    logic [2:0] obs_level;

    int n_checks = 0;
    int n_errors = 0;
    int ur_cnt0 = 0;
    int ur_cnt1 = 0;

    logic [127:0] din_cap, lr_cap;

    assign en0  = run & ~sel;
    assign en1  = run & sel;
    assign vld0 = in_valid & ~sel;
    assign vld1 = in_valid & sel;

    assign obs_ready = sel ? rdy1 : rdy0;
    assign obs_level = sel ? lvl1 : lvl0;
    assign obs_din   = sel ? din1 : din0;
    assign obs_lr    = sel ? lr1 : lr0;

    dac_i2s_tdm u_dut0 (
        .CLK        (CLK),
        .RESET_n    (RESET_n),
        .ENABLE     (en0),
        .MODE       (mode),
        .IN_VALID   (vld0),
        .IN_READY   (rdy0),
        .IN_DATA    (in_data[31:0]),
        .FIFO_LEVEL (lvl0),
        .UNDERRUN   (ur0),
        .BCLK       (BCLK),
        .LRCLK      (lr0),
        .DIN        (din0)
    );

    dac_i2s_tdm #(
        .SAMPLE_WIDTH (24),
        .SLOT_WIDTH   (32),
        .CHANNELS     (4),
        .FIFO_DEPTH   (4)
    ) u_dut1 (
        .CLK        (CLK),
        .RESET_n    (RESET_n),
        .ENABLE     (en1),
        .MODE       (mode),
        .IN_VALID   (vld1),
        .IN_READY   (rdy1),
        .IN_DATA    (in_data),
        .FIFO_LEVEL (lvl1),
        .UNDERRUN   (ur1),
        .BCLK       (BCLK),
        .LRCLK      (lr1),
        .DIN        (din1)
    );

    // CLK 100 MHz; BCLK period 80 ns, edges offset 2 ns from CLK edges.
    always #5 CLK = ~CLK;
    initial begin
        #2;
        forever #40 BCLK = ~BCLK;
    end

    always @(negedge CLK) begin
        if (ur0) ur_cnt0++;
        if (ur1) ur_cnt1++;
    end

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [127:0] got,
                             input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [95:0] d);
        int n;
        n = 0;
        @(negedge CLK);
        in_valid = 1'b1;
        in_data  = d;
        while (!obs_ready && n < 50) begin
            @(negedge CLK);
            n++;
        end
        check_val("push_ready", 128'(obs_ready), 128'd1);
        @(negedge CLK);
        in_valid = 1'b0;
    endtask

    // The next BCLK rising edge after this returns samples position p = 0.
    task automatic start_run;
        @(posedge BCLK);
        #1 run = 1'b1;
    endtask

    task automatic stop_run;
        #1 run = 1'b0;
    endtask

    // Sample pins at each BCLK rising edge, as the DAC does; first sample ends up MSB.
    task automatic capture(input int n);
        din_cap = '0;
        lr_cap  = '0;
        for (int i = 0; i < n; i++) begin
            @(posedge BCLK);
            din_cap = {din_cap[126:0], obs_din};
            lr_cap  = {lr_cap[126:0], obs_lr};
        end
    endtask

    logic [31:0]  frames [5];
    logic [127:0] exp_din;
    int           ur_base;

    initial begin
        frames[0] = {16'h1234, 16'hABCD};
        frames[1] = {16'h0F0F, 16'hF00F};
        frames[2] = {16'h7FFF, 16'h8000};
        frames[3] = {16'h5555, 16'hC3A5};
        frames[4] = {16'hFFFF, 16'hFFFF};

        // Reset and idle
        RESET_n = 1'b0;
        repeat (3) @(negedge CLK);
        check_val("rst_lrclk", 128'(lr0), 128'd0);
        check_val("rst_din", 128'(din0), 128'd0);
        check_val("rst_level", 128'(lvl0), 128'd0);
        check_val("rst_ready", 128'(rdy0), 128'd0);
        check_val("rst_underrun", 128'(ur0), 128'd0);
        RESET_n = 1'b1;
        check_val("rel_ready_now", 128'(rdy0), 128'd0);
        @(negedge CLK);
        check_val("rel_ready_next", 128'(rdy0), 128'd1);

        // I2S, one frame L=A5C3 R=8001
        mode = 2'd0;
        push({64'h0, 16'h8001, 16'hA5C3});
        check_val("i2s_level_in", 128'(lvl0), 128'd1);
        ur_base = ur_cnt0;
        start_run;
        capture(64);
        stop_run;
        check_val("i2s_din", din_cap, {64'h0, 1'b0, 16'hA5C3, 16'h0000, 16'h8001, 15'h0});
        check_val("i2s_lrclk", lr_cap, {64'h0, 32'h0, 32'hFFFF_FFFF});
        check_val("i2s_level_out", 128'(lvl0), 128'd0);
        check_val("i2s_underrun", 128'(ur_cnt0 - ur_base), 128'd0);

        // Right-justified, left slot only, L=8000
        mode = 2'd2;
        push({64'h0, 16'h0000, 16'h8000});
        ur_base = ur_cnt0;
        start_run;
        capture(32);
        stop_run;
        check_val("rj_din", din_cap, {96'h0, 17'h1FFFF, 15'h0});
        check_val("rj_lrclk", lr_cap, 128'h0);
        check_val("rj_underrun", 128'(ur_cnt0 - ur_base), 128'd0);

        // Left-justified on the 4-channel 24-bit instance
        sel  = 1'b1;
        mode = 2'd1;
        push({24'h000003, 24'h000002, 24'h000001, 24'h800000});
        ur_base = ur_cnt1;
        start_run;
        capture(128);
        stop_run;
        check_val("lj4_din", din_cap, {24'h800000, 8'h0, 24'h000001, 8'h0,
                                       24'h000002, 8'h0, 24'h000003, 8'h0});
        check_val("lj4_lrclk", lr_cap, {64'h0, 64'hFFFF_FFFF_FFFF_FFFF});
        check_val("lj4_underrun", 128'(ur_cnt1 - ur_base), 128'd0);
        sel = 1'b0;

        // FIFO full: five back-to-back writes, only four accepted
        @(negedge CLK);
        for (int i = 0; i < 5; i++) begin
            check_val($sformatf("full_ready_%0d", i), 128'(rdy0), (i < 4) ? 128'd1 : 128'd0);
            in_valid = 1'b1;
            in_data  = {64'h0, frames[i]};
            @(negedge CLK);
        end
        in_valid = 1'b0;
        check_val("full_level", 128'(lvl0), 128'd4);
        check_val("full_ready", 128'(rdy0), 128'd0);

        // Play five LJ frames; the fifth fetch underruns
        mode = 2'd1;
        ur_base = ur_cnt0;
        start_run;
        for (int f = 0; f < 5; f++) begin
            capture(64);
            if (f < 4) begin
                exp_din = {64'h0, frames[f][15:0], 16'h0, frames[f][31:16], 16'h0};
            end else begin
`ifdef DAC_I2S_TDM_HOLD_LAST_EN
                exp_din = {64'h0, frames[3][15:0], 16'h0, frames[3][31:16], 16'h0};
`else
                exp_din = '0;
`endif
            end
            check_val($sformatf("fifo_frame_%0d", f), din_cap, exp_din);
            check_val($sformatf("fifo_ur_%0d", f), 128'(ur_cnt0 - ur_base),
                      (f < 4) ? 128'd0 : 128'd1);
        end
        stop_run;
        check_val("fifo_level_end", 128'(lvl0), 128'd0);

        // Mid-frame reset at p = 20 with two frames still queued
        mode = 2'd2;
        for (int i = 0; i < 3; i++) push({64'h0, 16'h0000, 16'hFFFF});
        ur_base = ur_cnt0;
        start_run;
        capture(21);
        check_val("mid_din_pre", din_cap, 128'h1F_FFFF);
        check_val("mid_level_pre", 128'(lvl0), 128'd2);
        @(negedge CLK);
        RESET_n = 1'b0;
        @(negedge CLK);
        check_val("mid_rst_lrclk", 128'(lr0), 128'd0);
        check_val("mid_rst_din", 128'(din0), 128'd0);
        check_val("mid_rst_level", 128'(lvl0), 128'd0);
        @(negedge CLK);
        @(posedge BCLK);
        #1 RESET_n = 1'b1;
        ur_base = ur_cnt0;
        capture(64);
        stop_run;
        check_val("mid_restart_din", din_cap, 128'h0);
        check_val("mid_restart_lrclk", lr_cap, {64'h0, 32'h0, 32'hFFFF_FFFF});
        check_val("mid_restart_ur", 128'(ur_cnt0 - ur_base), 128'd1);

        repeat (4) @(negedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
